// File: rtl/draw_scheduler.sv
// draw_scheduler
//
// Per-frame scheduler and arbiter for the single VGA pixel-write port.
// On every accepted frame_tick the enabled sprite drawers are run one at a
// time, lowest index first. The active drawer's pixel bus is registered onto
// the adapter port. Drawers that hold the port too long are aborted.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   frame_tick       one-cycle pulse that starts a frame sequence
//   client_en        per-client enable, latched when a frame is accepted
//   client_finish    per-client finish_drawing handshake
//   client_x/y/color packed per-client pixel buses (8/7/3 bits per client)
//   client_draw      per-client draw enable, one-hot or zero
//   x, y, color      pixel coordinates/colour to the VGA adapter
//   plot             pixel write enable to the VGA adapter
//   busy             frame sequence in progress
//   active_client    index of the granted client, 0 when idle
//   frame_done       one-cycle pulse at the end of a frame sequence
//   overrun          sticky: a frame_tick was dropped because we were busy
//   timeout_err      sticky: some client was aborted by the timeout

module draw_scheduler #(
    parameter int NUM_CLIENTS = 3,
    parameter int TIMEOUT     = 4095,
    parameter int CW          = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [NUM_CLIENTS-1:0]   client_en,
    input  logic [NUM_CLIENTS-1:0]   client_finish,
    input  logic [8*NUM_CLIENTS-1:0] client_x,
    input  logic [7*NUM_CLIENTS-1:0] client_y,
    input  logic [3*NUM_CLIENTS-1:0] client_color,
    output logic [NUM_CLIENTS-1:0]   client_draw,
    output logic [7:0]               x,
    output logic [6:0]               y,
    output logic [2:0]               color,
    output logic                     plot,
    output logic                     busy,
    output logic [CW-1:0]            active_client,
    output logic                     frame_done,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        RUN,
        GAP,
        DONE
    } state_t;

    state_t                 state, state_next;
    logic [NUM_CLIENTS-1:0] mask, mask_next;
    logic [TW-1:0]          count, count_next;

    logic [NUM_CLIENTS-1:0] draw_next;
    logic [7:0]             x_next;
    logic [6:0]             y_next;
    logic [2:0]             color_next;
    logic                   plot_next;
    logic                   busy_next;
    logic [CW-1:0]          active_next;
    logic                   done_next;
    logic                   overrun_next;
    logic                   timeout_next;

    // Lowest pending client in the latched mask.
    logic                   pick_found;
    logic [CW-1:0]          pick_index;
    logic [NUM_CLIENTS-1:0] pick_onehot;

    // Bus slice and finish of the currently granted client.
    logic [7:0]             sel_x;
    logic [6:0]             sel_y;
    logic [2:0]             sel_color;
    logic                   sel_finish;
    logic                   timeout_hit;

    // Scanning from the top down lets the lowest set bit win.
    always_comb begin
        pick_found  = 1'b0;
        pick_index  = '0;
        pick_onehot = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (mask[k]) begin
                pick_found     = 1'b1;
                pick_index     = CW'(k);
                pick_onehot    = '0;
                pick_onehot[k] = 1'b1;
            end
        end
    end

    // Only the granted client's finish is looked at.
    // Finish from any other client is ignored.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_color  = '0;
        sel_finish = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (active_client == CW'(k)) begin
                sel_x      = client_x[8*k +: 8];
                sel_y      = client_y[7*k +: 7];
                sel_color  = client_color[3*k +: 3];
                sel_finish = client_finish[k];
            end
        end
    end

    // The count is the number of completed RUN cycles. The cycle in which it
    // would reach TIMEOUT is the last one the client is allowed. That cycle
    // aborts the grant instead of plotting.
    assign timeout_hit = (count == TW'(TIMEOUT - 1));

    always_comb begin
        state_next   = state;
        mask_next    = mask;
        count_next   = count;
        draw_next    = client_draw;
        x_next       = x;
        y_next       = y;
        color_next   = color;
        plot_next    = 1'b0;
        busy_next    = busy;
        active_next  = active_client;
        done_next    = 1'b0;
        overrun_next = overrun;
        timeout_next = timeout_err;

        // Any tick outside IDLE, including the DONE cycle, is dropped.
        if (frame_tick && (state != IDLE)) begin
            overrun_next = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (frame_tick) begin
                    mask_next  = client_en;
                    busy_next  = 1'b1;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (pick_found) begin
                    mask_next   = mask & ~pick_onehot;
                    active_next = pick_index;
                    count_next  = '0;
                    draw_next   = pick_onehot;
                    state_next  = RUN;
                end else begin
                    state_next = DONE;
                end
            end
            RUN: begin
                count_next = count + TW'(1);
                if (sel_finish) begin
                    draw_next  = '0;
                    state_next = GAP;
                end else if (timeout_hit) begin
                    draw_next    = '0;
                    timeout_next = 1'b1;
                    state_next   = GAP;
                end else begin
                    plot_next  = 1'b1;
                    x_next     = sel_x;
                    y_next     = sel_y;
                    color_next = sel_color;
                end
            end
            GAP: begin
                // This gives the previous client one low draw cycle. That
                // way a client which restarts on a held draw re-arms cleanly.
                draw_next  = '0;
                state_next = SELECT;
            end
            DONE: begin
                done_next   = 1'b1;
                busy_next   = 1'b0;
                active_next = '0;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            count         <= '0;
            client_draw   <= '0;
            x             <= '0;
            y             <= '0;
            color         <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            active_client <= '0;
            frame_done    <= 1'b0;
            overrun       <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            state         <= state_next;
            mask          <= mask_next;
            count         <= count_next;
            client_draw   <= draw_next;
            x             <= x_next;
            y             <= y_next;
            color         <= color_next;
            plot          <= plot_next;
            busy          <= busy_next;
            active_client <= active_next;
            frame_done    <= done_next;
            overrun       <= overrun_next;
            timeout_err   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler
//
// Self-checking bench for draw_scheduler. Three behavioural sprite clients
// each count their own draw cycles. A client finishes after a programmable
// number of pixels, or never, or holds finish permanently. Every pixel a
// client presents while it is granted is queued. The bench then expects that
// pixel on x/y/color with plot one cycle later.

module tb_draw_scheduler;

    localparam int NC  = 3;
    localparam int TO  = 50;
    localparam int CWD = 2;

    logic            clock;
    logic            reset;
    logic            frame_tick;
    logic [NC-1:0]   client_en;
    logic [NC-1:0]   client_finish;
    logic [8*NC-1:0] client_x;
    logic [7*NC-1:0] client_y;
    logic [3*NC-1:0] client_color;
    logic [NC-1:0]   client_draw;
    logic [7:0]      x;
    logic [6:0]      y;
    logic [2:0]      color;
    logic            plot;
    logic            busy;
    logic [CWD-1:0]  active_client;
    logic            frame_done;
    logic            overrun;
    logic            timeout_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Client model state.
    int        run_cnt [NC];
    int        fin_after [NC];
    logic [NC-1:0] hold_fin;

    typedef struct {
        int         client;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t exp_q[$];

    // Per-frame statistics gathered by the monitor.
    int draw_cyc [NC];
    int plot_cyc [NC];
    int grants[$];
    int acts[$];
    int gaps[$];
    int done_cnt;
    int zero_run;
    logic [NC-1:0] prev_draw;
    bit mon_en;

    draw_scheduler #(
        .NUM_CLIENTS(NC),
        .TIMEOUT    (TO),
        .CW         (CWD)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .client_en    (client_en),
        .client_finish(client_finish),
        .client_x     (client_x),
        .client_y     (client_y),
        .client_color (client_color),
        .client_draw  (client_draw),
        .x            (x),
        .y            (y),
        .color        (color),
        .plot         (plot),
        .busy         (busy),
        .active_client(active_client),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Each client counts how many cycles its draw line has been high.
    always @(posedge clock) begin
        for (int k = 0; k < NC; k++) begin
            run_cnt[k] <= client_draw[k] ? run_cnt[k] + 1 : 0;
        end
    end

    // The client pixel bus is a function of client index and pixel number.
    // Finish is raised once the requested pixel count has been presented.
    always_comb begin
        client_x      = '0;
        client_y      = '0;
        client_color  = '0;
        client_finish = '0;
        for (int k = 0; k < NC; k++) begin
            client_x[8*k +: 8]     = 8'(k * 64 + run_cnt[k] % 64);
            client_y[7*k +: 7]     = 7'(run_cnt[k] * 3 + k + 1);
            client_color[3*k +: 3] = 3'(run_cnt[k] + k + 1);
            if (hold_fin[k] || (client_draw[k] && fin_after[k] >= 0 && run_cnt[k] >= fin_after[k]))
                client_finish[k] = 1'b1;
        end
    end

    // The monitor samples on the falling edge. It first checks this cycle's
    // adapter port against the pixel queued one cycle earlier. It then
    // gathers frame statistics and queues the pixel the granted client shows.
    always @(negedge clock) begin
        pix_t e;
        pix_t p;
        if (mon_en) begin
            if (plot === 1'b1) begin
                n_compared++;
                if (exp_q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_plot: got plot=1 x=%0d y=%0d color=%0d expected plot=0", x, y, color);
                end else begin
                    e = exp_q.pop_front();
                    if ({x, y, color} !== {e.px, e.py, e.pc}) begin
                        n_mismatched++;
                        $display("[TB] FAIL pixel_bus: got x=%0d y=%0d color=%0d expected x=%0d y=%0d color=%0d",
                                 x, y, color, e.px, e.py, e.pc);
                    end
                    plot_cyc[e.client]++;
                end
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL missing_plot: got plot=%b expected plot=1 x=%0d", plot, e.px);
            end

            n_compared++;
            if ($countones(client_draw) > 1) begin
                n_mismatched++;
                $display("[TB] FAIL draw_onehot: got client_draw=%b expected one-hot or zero", client_draw);
            end

            if (frame_done === 1'b1) begin
                done_cnt++;
                n_compared++;
                if (busy !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL busy_at_done: got busy=%b expected 0", busy);
                end
            end

            for (int k = 0; k < NC; k++) begin
                if (client_draw[k]) draw_cyc[k]++;
            end
            if (client_draw != '0 && prev_draw == '0) begin
                if (grants.size() > 0) gaps.push_back(zero_run);
                for (int k = 0; k < NC; k++) begin
                    if (client_draw[k]) grants.push_back(k);
                end
                acts.push_back(int'(active_client));
            end
            zero_run  = (client_draw == '0) ? zero_run + 1 : 0;
            prev_draw = client_draw;

            if (!reset) begin
                for (int k = 0; k < NC; k++) begin
                    if (client_draw[k] && !client_finish[k] && run_cnt[k] < TO - 1) begin
                        p.client = k;
                        p.px     = client_x[8*k +: 8];
                        p.py     = client_y[7*k +: 7];
                        p.pc     = client_color[3*k +: 3];
                        exp_q.push_back(p);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < NC; k++) begin
            draw_cyc[k] = 0;
            plot_cyc[k] = 0;
        end
        grants.delete();
        acts.delete();
        gaps.delete();
        done_cnt = 0;
    endtask

    // Encodes a list of client indices as decimal digits (index+1).
    // For example, 0,1,2 becomes 123.
    function automatic int code_of(input bit use_acts);
        int c = 0;
        if (use_acts) foreach (acts[i]) c = c * 10 + acts[i] + 1;
        else          foreach (grants[i]) c = c * 10 + grants[i] + 1;
        return c;
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        frame_tick = 1'b0;
        cyc();
        mon_en = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    // The enable is flipped right after the tick. A correct frame ignores it.
    task automatic start_frame(input logic [NC-1:0] en);
        client_en  = en;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        client_en  = ~en;
    endtask

    task automatic wait_done(input int budget, input string name);
        int i = 0;
        while (done_cnt == 0 && i < budget) begin
            cyc();
            i++;
        end
        n_compared++;
        if (done_cnt == 0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_done_wait: got no frame_done expected one within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++; if (client_draw !== '0) begin n_mismatched++; $display("[TB] FAIL reset_draw: got %b expected 0", client_draw); end
        n_compared++; if (plot !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_plot: got %b expected 0", plot); end
        n_compared++; if ({x, y, color} !== 18'd0) begin n_mismatched++; $display("[TB] FAIL reset_pixel: got %0d/%0d/%0d expected 0/0/0", x, y, color); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_compared++; if (active_client !== '0) begin n_mismatched++; $display("[TB] FAIL reset_active: got %0d expected 0", active_client); end
        n_compared++; if (frame_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
        n_compared++; if ({overrun, timeout_err} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_sticky: got %b%b expected 00", overrun, timeout_err); end
    endtask

    task automatic test_full_frame();
        int exp_draw [NC] = '{11, 21, 31};
        int exp_plot [NC] = '{10, 20, 30};
        clear_stats();
        fin_after = '{10, 20, 30};
        start_frame(3'b111);
        wait_done(400, "full");
        repeat (3) cyc();
        n_compared++; if (code_of(0) !== 123) begin n_mismatched++; $display("[TB] FAIL full_grant_order: got %0d expected 123", code_of(0)); end
        for (int k = 0; k < NC; k++) begin
            n_compared++; if (draw_cyc[k] !== exp_draw[k]) begin n_mismatched++; $display("[TB] FAIL full_draw_cycles[%0d]: got %0d expected %0d", k, draw_cyc[k], exp_draw[k]); end
            n_compared++; if (plot_cyc[k] !== exp_plot[k]) begin n_mismatched++; $display("[TB] FAIL full_plot_cycles[%0d]: got %0d expected %0d", k, plot_cyc[k], exp_plot[k]); end
        end
        foreach (gaps[i]) begin
            n_compared++; if (gaps[i] < 1) begin n_mismatched++; $display("[TB] FAIL full_gap[%0d]: got %0d low cycles expected at least 1", i, gaps[i]); end
        end
        n_compared++; if (done_cnt !== 1) begin n_mismatched++; $display("[TB] FAIL full_done_count: got %0d expected 1", done_cnt); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL full_busy_after: got %b expected 0", busy); end
        n_compared++; if (active_client !== '0) begin n_mismatched++; $display("[TB] FAIL full_active_idle: got %0d expected 0", active_client); end
    endtask

    task automatic test_skip_client();
        clear_stats();
        fin_after = '{10, 20, 30};
        start_frame(3'b101);
        wait_done(400, "skip");
        repeat (3) cyc();
        n_compared++; if (code_of(0) !== 13) begin n_mismatched++; $display("[TB] FAIL skip_grant_order: got %0d expected 13", code_of(0)); end
        n_compared++; if (code_of(1) !== 13) begin n_mismatched++; $display("[TB] FAIL skip_active_seq: got %0d expected 13", code_of(1)); end
        n_compared++; if (draw_cyc[1] !== 0) begin n_mismatched++; $display("[TB] FAIL skip_client1_draw: got %0d expected 0", draw_cyc[1]); end
        n_compared++; if (plot_cyc[2] !== 30) begin n_mismatched++; $display("[TB] FAIL skip_client2_plot: got %0d expected 30", plot_cyc[2]); end
    endtask

    task automatic test_empty_frame();
        clear_stats();
        client_en  = 3'b000;
        frame_tick = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            frame_tick = 1'b0;
            client_en  = 3'b111;
            n_compared++;
            if (frame_done !== (i == 3)) begin
                n_mismatched++;
                $display("[TB] FAIL empty_done_timing[%0d]: got %b expected %b", i, frame_done, (i == 3));
            end
        end
        cyc();
        n_compared++; if (plot_cyc[0] + plot_cyc[1] + plot_cyc[2] !== 0) begin n_mismatched++; $display("[TB] FAIL empty_plot: got %0d plots expected 0", plot_cyc[0] + plot_cyc[1] + plot_cyc[2]); end
        n_compared++; if (grants.size() !== 0) begin n_mismatched++; $display("[TB] FAIL empty_grants: got %0d expected 0", grants.size()); end
    endtask

    task automatic test_timeout();
        n_compared++; if (timeout_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL timeout_err_before: got %b expected 0", timeout_err); end
        clear_stats();
        fin_after = '{10, -1, 30};
        start_frame(3'b111);
        wait_done(600, "timeout");
        repeat (3) cyc();
        n_compared++; if (draw_cyc[1] !== TO) begin n_mismatched++; $display("[TB] FAIL timeout_draw_cycles: got %0d expected %0d", draw_cyc[1], TO); end
        n_compared++; if (timeout_err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL timeout_err_set: got %b expected 1", timeout_err); end
        n_compared++; if (code_of(0) !== 123) begin n_mismatched++; $display("[TB] FAIL timeout_grant_order: got %0d expected 123", code_of(0)); end
        n_compared++; if (plot_cyc[2] !== 30) begin n_mismatched++; $display("[TB] FAIL timeout_client2_plot: got %0d expected 30", plot_cyc[2]); end
        n_compared++; if (done_cnt !== 1) begin n_mismatched++; $display("[TB] FAIL timeout_done_count: got %0d expected 1", done_cnt); end
        fin_after = '{10, 20, 30};
    endtask

    task automatic test_overrun();
        int i = 0;
        clear_stats();
        start_frame(3'b111);
        while (!client_draw[1] && i < 200) begin
            cyc();
            i++;
        end
        n_compared++; if (client_draw[1] !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_wait_grant1: got %b expected 1", client_draw[1]); end
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_compared++; if (overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_set: got %b expected 1", overrun); end
        wait_done(400, "overrun");
        repeat (10) cyc();
        n_compared++; if (done_cnt !== 1) begin n_mismatched++; $display("[TB] FAIL overrun_done_count: got %0d expected 1", done_cnt); end
        n_compared++; if (code_of(0) !== 123) begin n_mismatched++; $display("[TB] FAIL overrun_grants: got %0d expected 123", code_of(0)); end
        clear_stats();
        start_frame(3'b011);
        wait_done(400, "overrun_next");
        repeat (3) cyc();
        n_compared++; if (overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); end
        n_compared++; if (code_of(0) !== 12) begin n_mismatched++; $display("[TB] FAIL overrun_next_grants: got %0d expected 12", code_of(0)); end
    endtask

    task automatic test_tick_in_done();
        do_reset();
        n_compared++; if ({overrun, timeout_err} !== 2'b00) begin n_mismatched++; $display("[TB] FAIL done_tick_sticky_cleared: got %b%b expected 00", overrun, timeout_err); end
        clear_stats();
        client_en  = 3'b000;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        n_compared++; if (overrun !== 1'b1) begin n_mismatched++; $display("[TB] FAIL done_tick_overrun: got %b expected 1", overrun); end
        n_compared++; if (frame_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL done_tick_done: got %b expected 1", frame_done); end
        cyc();
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL done_tick_no_restart: got busy=%b expected 0", busy); end
        repeat (4) cyc();
        n_compared++; if (done_cnt !== 1) begin n_mismatched++; $display("[TB] FAIL done_tick_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        clear_stats();
        start_frame(3'b111);
        repeat (4) cyc();
        n_compared++; if (client_draw !== 3'b001) begin n_mismatched++; $display("[TB] FAIL midrst_pre_draw: got %b expected 001", client_draw); end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_compared++; if (client_draw !== '0) begin n_mismatched++; $display("[TB] FAIL midrst_draw: got %b expected 0", client_draw); end
        n_compared++; if (plot !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_plot: got %b expected 0", plot); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        repeat (5) cyc();
        n_compared++; if (done_cnt !== 0) begin n_mismatched++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_cnt); end

        reset      = 1'b1;
        frame_tick = 1'b1;
        client_en  = 3'b111;
        cyc();
        reset      = 1'b0;
        frame_tick = 1'b0;
        cyc();
        n_compared++; if ({busy, client_draw} !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL tick_with_reset: got busy=%b draw=%b expected 0/000", busy, client_draw); end

        clear_stats();
        start_frame(3'b111);
        wait_done(400, "restart");
        repeat (3) cyc();
        n_compared++; if (code_of(0) !== 123) begin n_mismatched++; $display("[TB] FAIL restart_grants: got %0d expected 123", code_of(0)); end
    endtask

    task automatic test_finish_held();
        clear_stats();
        hold_fin  = 3'b001;
        fin_after = '{10, 20, 30};
        start_frame(3'b111);
        wait_done(400, "held");
        repeat (3) cyc();
        hold_fin = 3'b000;
        n_compared++; if (draw_cyc[0] !== 1) begin n_mismatched++; $display("[TB] FAIL held_draw_cycles: got %0d expected 1", draw_cyc[0]); end
        n_compared++; if (plot_cyc[0] !== 0) begin n_mismatched++; $display("[TB] FAIL held_plot_cycles: got %0d expected 0", plot_cyc[0]); end
        n_compared++; if (plot_cyc[1] !== 20) begin n_mismatched++; $display("[TB] FAIL held_client1_plot: got %0d expected 20", plot_cyc[1]); end
        n_compared++; if (code_of(0) !== 123) begin n_mismatched++; $display("[TB] FAIL held_grants: got %0d expected 123", code_of(0)); end
    endtask

    initial begin
        reset      = 1'b1;
        frame_tick = 1'b0;
        client_en  = '0;
        hold_fin   = '0;
        fin_after  = '{10, 20, 30};
        mon_en     = 1'b0;
        done_cnt   = 0;
        zero_run   = 0;
        prev_draw  = '0;

        test_reset();
        test_full_frame();
        test_skip_client();
        test_empty_frame();
        test_timeout();
        test_overrun();
        test_tick_in_done();
        test_reset_mid_run();
        test_finish_held();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
